// File: rtl/selector_rr_arbiter_pkg.sv
// Shared definitions for the selector round-robin arbiter.
// Contents:
//   SEL_NONE/SEL_A/SEL_B/SEL_C : 2-bit select codes driven on SW
//   state_t                    : arbiter FSM states (ST_IDLE, ST_GRANT)
//   onehot_to_sel()            : converts a one-hot grant vector into its select code
package selector_rr_arbiter_pkg;

    localparam logic [1:0] SEL_NONE = 2'b00;
    localparam logic [1:0] SEL_A    = 2'b01;
    localparam logic [1:0] SEL_B    = 2'b10;
    localparam logic [1:0] SEL_C    = 2'b11;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // Bit 0 is A, bit 1 is B, bit 2 is C; anything that is not a single
    // valid requester maps to "none".
    function automatic logic [1:0] onehot_to_sel(input logic [2:0] onehot);
        logic [1:0] sel;
        sel = SEL_NONE;
        case (onehot)
            3'b001:  sel = SEL_A;
            3'b010:  sel = SEL_B;
            3'b100:  sel = SEL_C;
            default: sel = SEL_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/selector_rr_arbiter_rr_pick3.sv
// Combinational round-robin picker for three requesters.
// Ports:
//   req    [2:0] in  : request lines, bit0 = A, bit1 = B, bit2 = C
//   last   [1:0] in  : select code of the last served requester
//   winner [2:0] out : one-hot winner, 000 when nothing requests
//   any          out : at least one request is present
module rr_pick3
    import selector_rr_arbiter_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] last,
    output logic [2:0] winner,
    output logic       any
);

    // The search starts just after the last served requester and wraps
    // C -> A, so the last served one is always considered last. A "none"
    // pointer behaves like C so that A has first priority.
    always_comb begin
        winner = 3'b000;
        case (last)
            SEL_A: begin
                if (req[1])      winner = 3'b010;
                else if (req[2]) winner = 3'b100;
                else if (req[0]) winner = 3'b001;
            end
            SEL_B: begin
                if (req[2])      winner = 3'b100;
                else if (req[0]) winner = 3'b001;
                else if (req[1]) winner = 3'b010;
            end
            default: begin
                if (req[0])      winner = 3'b001;
                else if (req[1]) winner = 3'b010;
                else if (req[2]) winner = 3'b100;
            end
        endcase
    end

    assign any = |req;

endmodule

// File: rtl/selector_rr_arbiter.sv
// Round-robin arbiter that shares the 3-source, 3-bit selector datapath
// between requesters A, B and C. Fairness comes from a rotating
// last-served pointer plus a maximum hold time per grant under contention.
// Parameters:
//   HOLD : maximum consecutive cycles a grant is kept while another waits (1..15)
//   CW   : hold counter width, 2**CW > HOLD
// Ports:
//   CLK       in  : system clock, rising edge
//   RST_N     in  : asynchronous active-low reset
//   REQ [2:0] in  : request lines, bit0 = A, bit1 = B, bit2 = C
//   A/B/C [2:0] in: data of each requester
//   GNT [2:0] out : registered one-hot grant, 000 when idle
//   SW  [1:0] out : registered select code (00 none, 01 A, 10 B, 11 C)
//   O   [2:0] out : data of the granted requester, 000 when idle
//   EN        out : grant active (SW != 00)
module selector_rr_arbiter
    import selector_rr_arbiter_pkg::*;
#(
    parameter int HOLD = 4,
    parameter int CW   = 4
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [2:0] REQ,
    input  logic [2:0] A,
    input  logic [2:0] B,
    input  logic [2:0] C,
    output logic [2:0] GNT,
    output logic [1:0] SW,
    output logic [2:0] O,
    output logic       EN
);

    localparam logic [CW-1:0] RELOAD = CW'(HOLD - 1);

    state_t        state;
    logic [1:0]    last;
    logic [CW-1:0] cnt;
    logic [2:0]    winner;
    logic          any;
    logic          owner_req;
    logic          others_req;

    rr_pick3 u_pick (
        .req    (REQ),
        .last   (last),
        .winner (winner),
        .any    (any)
    );

    assign owner_req  = |(REQ & GNT);
    assign others_req = |(REQ & ~GNT);

    // While a grant is active the pointer equals the current owner, so the
    // picker naturally ranks the owner last when choosing a successor on
    // release or expiry. The counter only gates expiry; an uncontended owner
    // simply reloads it and keeps the grant.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= ST_IDLE;
            GNT   <= 3'b000;
            SW    <= SEL_NONE;
            cnt   <= '0;
            last  <= SEL_C;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any) begin
                        state <= ST_GRANT;
                        GNT   <= winner;
                        SW    <= onehot_to_sel(winner);
                        last  <= onehot_to_sel(winner);
                        cnt   <= RELOAD;
                    end
                end
                ST_GRANT: begin
                    if (!owner_req) begin
                        if (any) begin
                            GNT  <= winner;
                            SW   <= onehot_to_sel(winner);
                            last <= onehot_to_sel(winner);
                            cnt  <= RELOAD;
                        end else begin
                            state <= ST_IDLE;
                            GNT   <= 3'b000;
                            SW    <= SEL_NONE;
                            cnt   <= '0;
                        end
                    end else if (cnt == '0) begin
                        if (others_req) begin
                            GNT  <= winner;
                            SW   <= onehot_to_sel(winner);
                            last <= onehot_to_sel(winner);
                        end
                        cnt <= RELOAD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    GNT   <= 3'b000;
                    SW    <= SEL_NONE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Output mux follows the registered select code; idle forces zeros so
    // no requester data leaks downstream.
    always_comb begin
        O = 3'b000;
        case (SW)
            SEL_A:   O = A;
            SEL_B:   O = B;
            SEL_C:   O = C;
            default: O = 3'b000;
        endcase
    end

    assign EN = (SW != SEL_NONE);

endmodule

// File: tb/tb_selector_rr_arbiter.sv
// Self-checking bench for selector_rr_arbiter. Two instances (HOLD = 4 and
// HOLD = 1) share all inputs; a behavioural model tracks owner, cycles held
// and last served requester for each and is compared every cycle.
module tb_selector_rr_arbiter;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic [2:0] REQ = 3'b000;
    logic [2:0] A = 3'd0;
    logic [2:0] B = 3'd0;
    logic [2:0] C = 3'd0;

    logic [2:0] gnt4, gnt1, o4, o1;
    logic [1:0] sw4, sw1;
    logic       en4, en1;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    selector_rr_arbiter #(.HOLD(4), .CW(4)) u_hold4 (
        .CLK(CLK), .RST_N(RST_N), .REQ(REQ), .A(A), .B(B), .C(C),
        .GNT(gnt4), .SW(sw4), .O(o4), .EN(en4)
    );

    selector_rr_arbiter #(.HOLD(1), .CW(4)) u_hold1 (
        .CLK(CLK), .RST_N(RST_N), .REQ(REQ), .A(A), .B(B), .C(C),
        .GNT(gnt1), .SW(sw1), .O(o1), .EN(en1)
    );

    // Behavioural model: owner index (0=A,1=B,2=C,-1 none), cycles the
    // current grant has been held, index of last served requester.
    int owner[2]    = '{-1, -1};
    int held[2]     = '{0, 0};
    int last_idx[2] = '{2, 2};
    int hold_len[2] = '{4, 1};

    function automatic int rr_next(input logic [2:0] r, input int from);
        for (int i = 1; i <= 3; i++) begin
            int idx;
            idx = (from + i) % 3;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic void model_step(input int own, input int hcnt, input int lst,
                                       input logic [2:0] r, input int hold,
                                       output int n_own, output int n_held, output int n_last);
        int w;
        w      = rr_next(r, lst);
        n_own  = own;
        n_held = hcnt;
        n_last = lst;
        if (own < 0) begin
            n_own  = w;
            n_held = (w < 0) ? 0 : 1;
            if (w >= 0) n_last = w;
        end else if (!r[own]) begin
            n_own  = w;
            n_held = (w < 0) ? 0 : 1;
            if (w >= 0) n_last = w;
        end else if (hcnt >= hold) begin
            // Expired: next round-robin requester, or the owner again if alone.
            n_own  = w;
            n_held = 1;
            n_last = w;
        end else begin
            n_held = hcnt + 1;
        end
    endfunction

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int k = 0; k < 2; k++) begin
                owner[k]    <= -1;
                held[k]     <= 0;
                last_idx[k] <= 2;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                int no, nh, nl;
                model_step(owner[k], held[k], last_idx[k], REQ, hold_len[k], no, nh, nl);
                owner[k]    <= no;
                held[k]     <= nh;
                last_idx[k] <= nl;
            end
        end
    end

    function automatic logic [8:0] expected_outputs(input int own, input logic [2:0] a,
                                                    input logic [2:0] b, input logic [2:0] c);
        logic [2:0] g, d;
        logic [1:0] s;
        if (own < 0) return 9'd0;
        g = 3'b001 << own;
        s = 2'(own + 1);
        d = (own == 0) ? a : (own == 1) ? b : c;
        return {g, s, d, 1'b1};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, actual, required);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] req, input logic [2:0] a,
                                 input logic [2:0] b, input logic [2:0] c);
        #1;
        REQ = req;
        A   = a;
        B   = b;
        C   = c;
        @(negedge CLK);
    endtask

    // Every-cycle comparison of both instances against the model.
    initial begin
        forever begin
            @(negedge CLK);
            checkOutput("hold4_outputs", {23'd0, gnt4, sw4, o4, en4},
                        {23'd0, expected_outputs(owner[0], A, B, C)});
            checkOutput("hold1_outputs", {23'd0, gnt1, sw1, o1, en1},
                        {23'd0, expected_outputs(owner[1], A, B, C)});
        end
    end

    initial begin
        logic [2:0] rr_order [3];
        logic [2:0] d;
        logic [2:0] cur_req;
        rr_order[0] = 3'b001;
        rr_order[1] = 3'b010;
        rr_order[2] = 3'b100;

        // Reset held with all requests pending.
        RST_N = 1'b0;
        repeat (3) applyStimulus(3'b111, 3'd5, 3'd3, 3'd6);
        checkOutput("reset_gnt", {29'd0, gnt4}, 32'h0);
        checkOutput("reset_sw_en_o", {26'd0, sw4, en4, o4}, 32'h0);
        #1 RST_N = 1'b1;

        // First edge after reset: A wins, and under full contention the
        // HOLD=4 instance rotates A,B,C every 4 cycles; HOLD=1 every cycle.
        for (int k = 0; k < 13; k++) begin
            applyStimulus(3'b111, (k == 0) ? 3'd5 : 3'($urandom_range(0, 7)), 3'd3, 3'd6);
            if (k == 0) begin
                checkOutput("first_grant_gnt", {29'd0, gnt4}, 32'h1);
                checkOutput("first_grant_sw", {30'd0, sw4}, 32'h1);
                checkOutput("first_grant_en_o", {28'd0, en4, o4}, 32'hd);
            end
            checkOutput("rotate_hold4", {29'd0, gnt4}, {29'd0, rr_order[(k / 4) % 3]});
            checkOutput("rotate_hold1", {29'd0, gnt1}, {29'd0, rr_order[k % 3]});
        end

        // Only B requests: grant sticks and O tracks B.
        for (int k = 0; k < 20; k++) begin
            d = 3'($urandom_range(0, 7));
            applyStimulus(3'b010, 3'd1, d, 3'd2);
            checkOutput("solo_b_gnt", {29'd0, gnt4}, 32'h2);
            checkOutput("solo_b_o", {29'd0, o4}, {29'd0, d});
        end
        applyStimulus(3'b000, 3'd1, 3'd4, 3'd2);
        checkOutput("drop_b_idle", {26'd0, gnt4, en4, o4}, 32'h0);

        // A granted, then A drops on the same edge C rises.
        applyStimulus(3'b001, 3'd3, 3'd4, 3'd7);
        checkOutput("a_only_gnt", {29'd0, gnt4}, 32'h1);
        applyStimulus(3'b100, 3'd3, 3'd4, 3'd7);
        checkOutput("handoff_c", {24'd0, gnt4, sw4, o4}, {24'd0, 3'b100, 2'b11, 3'd7});

        // Asynchronous reset between clock edges.
        #2 RST_N = 1'b0;
        #1;
        checkOutput("async_reset", {23'd0, gnt4, sw4, en4, o4}, 32'h0);
        REQ = 3'b110;
        @(negedge CLK);
        #1 RST_N = 1'b1;
        applyStimulus(3'b110, 3'd0, 3'd2, 3'd5);
        checkOutput("post_reset_b", {29'd0, gnt4}, 32'h2);

        // HOLD=1 instance alternates between the two requesters every cycle.
        for (int k = 0; k < 6; k++) begin
            applyStimulus(3'b101, 3'd1, 3'd2, 3'd3);
            checkOutput("hold1_alternate", {29'd0, gnt1}, (k % 2 == 0) ? 32'h4 : 32'h1);
        end

        // Randomized traffic with occasional asynchronous resets.
        cur_req = 3'b000;
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 3) == 0) cur_req = 3'($urandom_range(0, 7));
            applyStimulus(cur_req, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                          3'($urandom_range(0, 7)));
            if ($urandom_range(0, 199) == 0) begin
                #3 RST_N = 1'b0;
                #3 RST_N = 1'b1;
            end
        end

        @(negedge CLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
